neuron_recall: RTL

//   Recall-side counterpart of the Hebbian weight learner. Consumes one neuron's packed

---
 rtl/neuron_recall_if.sv | 27 ++
 rtl/neuron_recall.sv | 100 ++++++++++
 2 files changed

// File: rtl/neuron_recall_if.sv
// Request/result bundle between the neuron-update sequencer (master) and the
// serial recall datapath (slave).
interface neuron_recall_if #(
  parameter int N    = 20,
  parameter int WW   = 10,
  parameter int NW   = 2,
  parameter int ACCW = WW + NW + 5
) ();
  logic              start;
  logic [N*WW-1:0]   weights_packed;
  logic [N*NW-1:0]   xalt;
  logic [NW-1:0]     xself;
  logic              busy;
  logic              done;
  logic [NW-1:0]     xout;
  logic [ACCW-1:0]   sum_out;

  modport master (
    output start, weights_packed, xalt, xself,
    input  busy, done, xout, sum_out
  );

  modport slave (
    input  start, weights_packed, xalt, xself,
    output busy, done, xout, sum_out
  );
endinterface

// File: rtl/neuron_recall.sv
// Serial Hopfield recall: snapshots one weight row and all neuron states, accumulates
// sum(w[j]*x[j]) one term per clock, then emits sign(sum) as the neuron's next state.
module neuron_recall #(
  parameter int N    = 20,
  parameter int WW   = 10,
  parameter int NW   = 2,
  parameter int ACCW = WW + NW + 5
) (
  input  logic           recall_clock,
  input  logic           rst_n,
  neuron_recall_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = WW + NW;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_FIN} state_t;

  state_t                r_state;
  logic signed [WW-1:0]  r_w [N];
  logic signed [NW-1:0]  r_x [N];
  logic [NW-1:0]         r_xself;
  logic signed [ACCW-1:0] r_acc;
  logic [IW-1:0]         r_idx;
  logic                  r_busy;
  logic                  r_done;
  logic [NW-1:0]         r_xout;
  logic signed [ACCW-1:0] r_sum;

  logic signed [PW-1:0]   w_prod;
  logic signed [ACCW-1:0] w_term;
  logic signed [ACCW-1:0] w_acc_nxt;

  // Zero sum keeps the neuron's current state rather than forcing a polarity.
  function automatic logic [NW-1:0] f_sign(input logic signed [ACCW-1:0] acc,
                                           input logic [NW-1:0] tie);
    if (acc[ACCW-1])      return '1;
    else if (acc != '0)   return NW'(1);
    else                  return tie;
  endfunction

  assign w_prod    = PW'(r_w[r_idx]) * PW'(r_x[r_idx]);
  assign w_term    = ACCW'(w_prod);
  assign w_acc_nxt = r_acc + w_term;

  always_ff @(posedge recall_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_xout  <= '0;
      r_sum   <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_xself <= '0;
      for (int j = 0; j < N; j++) begin
        r_w[j] <= '0;
        r_x[j] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            for (int j = 0; j < N; j++) begin
              r_w[j] <= bus.weights_packed[j*WW +: WW];
              r_x[j] <= bus.xalt[j*NW +: NW];
            end
            r_xself <= bus.xself;
            r_acc   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          r_acc <= w_acc_nxt;
          if (r_idx == IW'(N - 1)) begin
            r_sum   <= w_acc_nxt;
            r_xout  <= f_sign(w_acc_nxt, r_xself);
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.xout    = r_xout;
  assign bus.sum_out = r_sum;
endmodule
